svi_bus_arbiter: RTL and testbench

- Parametrised N-channel successor to the shared scalar-member interface bundle {z, y, x}.
- Instead of several modules driving the same interface members directly, each client channel presents a WIDTH-bit {z, y, x} triple with a valid/ready handshake.
- The block arbitrates round-robin and registers the winner onto a single shared output bundle with its own valid/ready handshake.
- It sits between the client modules and the one shared interface instance, removing multi-driver conflicts.

---
 rtl/svi_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_svi_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : svi_bus_arbiter
//  Purpose  : N-channel round-robin arbiter feeding one registered {z,y,x}
//             bundle with a valid/ready handshake, so a single owner drives
//             the shared interface instance instead of many modules.
//  Option   : define SVI_BUS_ARB_LOCK_EN to add req_lock, which lets the
//             winning channel hold round-robin priority while it requests.
//  Revision : 1.0 - initial release
// ============================================================================
module svi_bus_arbiter #(
    parameter int NCH   = 4,
    parameter int WIDTH = 1,
    parameter int CNT_W = 16,
    parameter int SRC_W = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       req_valid,
    output logic [NCH-1:0]       req_ready,
    input  logic [NCH*WIDTH-1:0] req_z,
    input  logic [NCH*WIDTH-1:0] req_y,
    input  logic [NCH*WIDTH-1:0] req_x,
`ifdef SVI_BUS_ARB_LOCK_EN
    input  logic [NCH-1:0]       req_lock,
`endif
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic [WIDTH-1:0]     bus_z,
    output logic [WIDTH-1:0]     bus_y,
    output logic [WIDTH-1:0]     bus_x,
    output logic [SRC_W-1:0]     bus_src,
    output logic [CNT_W-1:0]     xfer_cnt
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [SRC_W:0]   c_nch_ext = (SRC_W+1)'(NCH);
    localparam logic [SRC_W-1:0] c_last_ch = SRC_W'(NCH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SRC_W-1:0]   r_rr_ptr;
    logic [WIDTH-1:0]   r_bus_z;
    logic [WIDTH-1:0]   r_bus_y;
    logic [WIDTH-1:0]   r_bus_x;
    logic [SRC_W-1:0]   r_bus_src;
    logic [CNT_W-1:0]   r_xfer_cnt;

    logic [SRC_W:0]     w_idx;
    logic [SRC_W-1:0]   w_win;
    logic [SRC_W-1:0]   w_win_inc;
    logic               w_found;
    logic               w_cap_ok;
    logic               w_cap;
    logic [NCH-1:0]     w_ready;

    // Rotating priority search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        w_idx   = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
            if (w_idx >= c_nch_ext) begin
                w_idx = w_idx - c_nch_ext;
            end
            if (!w_found && req_valid[w_idx[SRC_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[SRC_W-1:0];
            end
        end
    end

    // Capture whenever the output slot is free or being drained this cycle;
    // reset forces the grant low so nothing is accepted while held in reset.
    assign w_cap_ok  = (r_state == ST_EMPTY) || bus_ready;
    assign w_cap     = rst_n && w_cap_ok && w_found;
    assign w_win_inc = (w_win == c_last_ch) ? '0 : w_win + SRC_W'(1);

    // One-hot grant to the selected channel only on a capture cycle.
    always_comb begin
        w_ready = '0;
        if (w_cap) begin
            w_ready[w_win] = 1'b1;
        end
    end

    // Output-slot occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot fills on capture; empties on drain unless a new winner refills it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_cap) w_state_nxt = ST_FULL;
            ST_FULL:  if (bus_ready && !w_cap) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Bundle register: loads only on capture, otherwise holds the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_z   <= '0;
            r_bus_y   <= '0;
            r_bus_x   <= '0;
            r_bus_src <= '0;
        end else if (w_cap) begin
            r_bus_z   <= req_z[w_win*WIDTH +: WIDTH];
            r_bus_y   <= req_y[w_win*WIDTH +: WIDTH];
            r_bus_x   <= req_x[w_win*WIDTH +: WIDTH];
            r_bus_src <= w_win;
        end
    end

    // Completed-transfer counter, free-running wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if ((r_state == ST_FULL) && bus_ready) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
        end
    end

`ifdef SVI_BUS_ARB_LOCK_EN
    logic             r_lock_act;
    logic [SRC_W-1:0] r_lock_ch;
    logic [SRC_W-1:0] w_lock_inc;

    assign w_lock_inc = (r_lock_ch == c_last_ch) ? '0 : r_lock_ch + SRC_W'(1);

    // Pointer parks on a locked winner; releases on an unlocked capture or
    // when the locked channel stops requesting while the slot is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_lock_act <= 1'b0;
            r_lock_ch  <= '0;
        end else if (w_cap) begin
            if (req_lock[w_win]) begin
                r_rr_ptr   <= w_win;
                r_lock_act <= 1'b1;
                r_lock_ch  <= w_win;
            end else begin
                r_rr_ptr   <= w_win_inc;
                r_lock_act <= 1'b0;
            end
        end else if (r_lock_act && (r_state == ST_EMPTY) && !req_valid[r_lock_ch]) begin
            r_rr_ptr   <= w_lock_inc;
            r_lock_act <= 1'b0;
        end
    end
`else
    // Pointer advances past each capture winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_cap) begin
            r_rr_ptr <= w_win_inc;
        end
    end
`endif

    assign req_ready = w_ready;
    assign bus_valid = (r_state == ST_FULL);
    assign bus_z     = r_bus_z;
    assign bus_y     = r_bus_y;
    assign bus_x     = r_bus_x;
    assign bus_src   = r_bus_src;
    assign xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_svi_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_svi_bus_arbiter
//  Purpose  : Self-checking bench for svi_bus_arbiter (NCH=4, WIDTH=8) with a
//             reference model and scoreboard of expected output bundles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_svi_bus_arbiter;

    localparam int NCH   = 4;
    localparam int WIDTH = 8;
    localparam int CNT_W = 16;
    localparam int SRC_W = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NCH-1:0]       req_valid = '0;
    logic [NCH-1:0]       req_ready;
    logic [NCH*WIDTH-1:0] req_z = '0;
    logic [NCH*WIDTH-1:0] req_y = '0;
    logic [NCH*WIDTH-1:0] req_x = '0;
`ifdef SVI_BUS_ARB_LOCK_EN
    logic [NCH-1:0]       req_lock = '0;
`endif
    logic                 bus_valid;
    logic                 bus_ready = 1'b0;
    logic [WIDTH-1:0]     bus_z;
    logic [WIDTH-1:0]     bus_y;
    logic [WIDTH-1:0]     bus_x;
    logic [SRC_W-1:0]     bus_src;
    logic [CNT_W-1:0]     xfer_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [WIDTH-1:0] z;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] x;
        logic [SRC_W-1:0] src;
    } bundle_t;

    bundle_t          sb_q[$];
    bundle_t          m_bnd;
    bundle_t          m_got;
    logic             m_full = 1'b0;
    int               m_ptr = 0;
    logic [CNT_W-1:0] m_cnt = '0;
    int               m_win;
    logic             m_found;
    logic [NCH-1:0]   m_rdy;

    always #5 clk = ~clk;

    svi_bus_arbiter #(
        .NCH   (NCH),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .SRC_W (SRC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_z     (req_z),
        .req_y     (req_y),
        .req_x     (req_x),
`ifdef SVI_BUS_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_z     (bus_z),
        .bus_y     (bus_y),
        .bus_x     (bus_x),
        .bus_src   (bus_src),
        .xfer_cnt  (xfer_cnt)
    );

    // Reference model: checks the current cycle, then predicts the next edge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full = 1'b0;
            m_ptr  = 0;
            m_cnt  = '0;
            sb_q.delete();
        end else begin
            checks++;
            if (bus_valid !== m_full) begin
                errors++;
                $display("FAIL sb_valid: got %b expected %b at %0t", bus_valid, m_full, $time);
            end
            if (m_full && sb_q.size() > 0) begin
                m_got = {bus_z, bus_y, bus_x, bus_src};
                checks++;
                if (m_got !== sb_q[0]) begin
                    errors++;
                    $display("FAIL sb_bundle: got %h expected %h at %0t", m_got, sb_q[0], $time);
                end
            end
            checks++;
            if (xfer_cnt !== m_cnt) begin
                errors++;
                $display("FAIL sb_cnt: got %0d expected %0d at %0t", xfer_cnt, m_cnt, $time);
            end
            m_found = 1'b0;
            m_win   = 0;
            for (int k = 0; k < NCH; k++) begin
                if (!m_found && req_valid[(m_ptr + k) % NCH]) begin
                    m_found = 1'b1;
                    m_win   = (m_ptr + k) % NCH;
                end
            end
            m_rdy = '0;
            if ((!m_full || bus_ready) && m_found) m_rdy[m_win] = 1'b1;
            checks++;
            if (req_ready !== m_rdy) begin
                errors++;
                $display("FAIL sb_ready: got %b expected %b at %0t", req_ready, m_rdy, $time);
            end
            if (m_full && bus_ready) begin
                if (sb_q.size() > 0) void'(sb_q.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            if (m_rdy != '0) begin
                m_bnd = {req_z[m_win*WIDTH +: WIDTH], req_y[m_win*WIDTH +: WIDTH],
                         req_x[m_win*WIDTH +: WIDTH], SRC_W'(m_win)};
                sb_q.push_back(m_bnd);
                m_ptr  = (m_win + 1) % NCH;
                m_full = 1'b1;
            end else if (m_full && bus_ready) begin
                m_full = 1'b0;
            end
        end
    end

    task automatic set_data(input int ch, input logic [7:0] z, input logic [7:0] y, input logic [7:0] x);
        req_z[ch*WIDTH +: WIDTH] = z;
        req_y[ch*WIDTH +: WIDTH] = y;
        req_x[ch*WIDTH +: WIDTH] = x;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req_valid = '0; bus_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; bus_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks += 3;
            if (bus_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus_valid); end
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
            if (xfer_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", xfer_cnt); end
        end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        set_data(2, 8'hA5, 8'h3C, 8'h0F);
        req_valid = 4'b0100; bus_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        set_data(2, 8'hFF, 8'hFF, 8'hFF);
        @(negedge clk);
        checks += 6;
        if (bus_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus_valid); end
        if (bus_z !== 8'hA5) begin errors++; $display("FAIL single_z: got %h expected a5", bus_z); end
        if (bus_y !== 8'h3C) begin errors++; $display("FAIL single_y: got %h expected 3c", bus_y); end
        if (bus_x !== 8'h0F) begin errors++; $display("FAIL single_x: got %h expected 0f", bus_x); end
        if (bus_src !== 2'd2) begin errors++; $display("FAIL single_src: got %0d expected 2", bus_src); end
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready2: got %b expected 0000", req_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks += 2;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", bus_valid); end
        if (xfer_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", xfer_cnt); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < NCH; c++) set_data(c, 8'h10 + 8'(c), 8'h20 + 8'(c), 8'h30 + 8'(c));
        req_valid = 4'b1111; bus_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 5) req_valid = '0;
            @(negedge clk);
            checks += 3;
            if (bus_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b expected 1", i, bus_valid); end
            if (bus_src !== 2'(i % 4)) begin errors++; $display("FAIL rr_src[%0d]: got %0d expected %0d", i, bus_src, i % 4); end
            if (bus_z !== 8'h10 + 8'(i % 4)) begin errors++; $display("FAIL rr_z[%0d]: got %h expected %h", i, bus_z, 8'h10 + 8'(i % 4)); end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks += 2;
        if (xfer_cnt !== 16'd6) begin errors++; $display("FAIL rr_cnt: got %0d expected 6", xfer_cnt); end
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0", bus_valid); end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        req_valid = 4'b1111; bus_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks += 4;
            if (bus_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, bus_valid); end
            if (bus_src !== 2'd2) begin errors++; $display("FAIL bp_src[%0d]: got %0d expected 2", i, bus_src); end
            if (bus_z !== 8'h12) begin errors++; $display("FAIL bp_z[%0d]: got %h expected 12", i, bus_z); end
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, req_ready); end
            @(posedge clk); #1;
        end
        bus_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready: got %b expected 1000", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks += 2;
        if (bus_src !== 2'd3) begin errors++; $display("FAIL bp_next_src: got %0d expected 3", bus_src); end
        if (bus_z !== 8'h13) begin errors++; $display("FAIL bp_next_z: got %h expected 13", bus_z); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (xfer_cnt !== 16'd8) begin errors++; $display("FAIL bp_cnt: got %0d expected 8", xfer_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid = 4'b0001; bus_ready = 1'b1;
        repeat (65536) @(posedge clk);
        @(negedge clk);
        checks++;
        if (xfer_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %h expected ffff", xfer_cnt); end
        @(negedge clk);
        checks++;
        if (xfer_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", xfer_cnt); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        set_data(1, 8'h5A, 8'h6B, 8'h7C);
        req_valid = 4'b0010; bus_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (bus_valid !== 1'b1) begin errors++; $display("FAIL ar_full: got %b expected 1", bus_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL ar_async_valid: got %b expected 0", bus_valid); end
        if (bus_src !== 2'd0) begin errors++; $display("FAIL ar_async_src: got %0d expected 0", bus_src); end
        if (bus_z !== 8'h00) begin errors++; $display("FAIL ar_async_z: got %h expected 00", bus_z); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_data(0, 8'hC0, 8'hC1, 8'hC2);
        set_data(3, 8'hD0, 8'hD1, 8'hD2);
        req_valid = 4'b1001; bus_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL ar_first_ready: got %b expected 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'b1000;
        @(negedge clk);
        checks += 2;
        if (bus_src !== 2'd0) begin errors++; $display("FAIL ar_first_src: got %0d expected 0", bus_src); end
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL ar_second_ready: got %b expected 1000", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (bus_src !== 2'd3) begin errors++; $display("FAIL ar_second_src: got %0d expected 3", bus_src); end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_async_reset();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
